// File: rtl/ft600_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ft600_fifo
// Purpose  : FT600-style bridge between per-channel RX/TX FIFOs and a shared
//            tri-state client bus. Define FT600_FIFO_ERR_EN to add err_flags.
// Revision : 1.0
// ============================================================================
module ft600_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 1,
    parameter int FIFO_DEPTH = 32,
    parameter int USE_BE     = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inout  wire  [DATA_WIDTH-1:0] data,
    inout  wire  [BE_W-1:0]       be,
    input  logic                  oe_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    output logic [NUM_CH-1:0]     rxf_n,
    output logic [NUM_CH-1:0]     txe_n,
    input  logic [CH_W-1:0]       rd_ch_sel,
    input  logic [CH_W-1:0]       wr_ch_sel,
    input  logic                  rx_host_wr_en,
    input  logic [CH_W-1:0]       rx_host_wr_ch,
    input  logic [DATA_WIDTH-1:0] rx_host_wr_data,
    input  logic [BE_W-1:0]       rx_host_wr_be,
    input  logic                  tx_host_rd_en,
    input  logic [CH_W-1:0]       tx_host_rd_ch,
    output logic                  tx_host_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_host_rd_data,
    output logic [BE_W-1:0]       tx_host_rd_be
`ifdef FT600_FIFO_ERR_EN
    ,
    output logic [3:0]            err_flags
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = DATA_WIDTH + BE_W;
    localparam logic [CW-1:0]   C_FULL    = CW'(FIFO_DEPTH);
    localparam logic [BE_W-1:0] C_BE_ONES = '1;

    logic [WW-1:0]     w_rx_head [NUM_CH];
    logic [WW-1:0]     w_tx_head [NUM_CH];
    logic [NUM_CH-1:0] w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic [NUM_CH-1:0] w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic [WW-1:0]     w_rx_sel_head, w_tx_sel_head, w_bus_word;
    logic              w_rx_sel_empty;
    logic [BE_W-1:0]   w_host_be, w_bus_be;
    logic              w_client_rd, w_client_wr;

    // The bus direction is owned by oe_n, so each strobe only counts in its own phase
    assign w_client_rd = !oe_n && !rd_n;
    assign w_client_wr = oe_n && !wr_n;
    assign w_host_be   = (USE_BE != 0) ? rx_host_wr_be : C_BE_ONES;
    assign w_bus_be    = (USE_BE != 0) ? be : C_BE_ONES;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [WW-1:0] r_rx_mem [FIFO_DEPTH];
        logic [WW-1:0] r_tx_mem [FIFO_DEPTH];
        logic [AW-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
        logic [CW-1:0] r_rx_cnt, r_tx_cnt;

        assign w_rx_empty[ch] = (r_rx_cnt == '0);
        assign w_rx_full[ch]  = (r_rx_cnt == C_FULL);
        assign w_tx_empty[ch] = (r_tx_cnt == '0);
        assign w_tx_full[ch]  = (r_tx_cnt == C_FULL);

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        assign w_rx_pop[ch]  = w_client_rd && (rd_ch_sel == CH_W'(ch)) && !w_rx_empty[ch];
        assign w_rx_push[ch] = rx_host_wr_en && (rx_host_wr_ch == CH_W'(ch))
                               && (!w_rx_full[ch] || w_rx_pop[ch]);
        assign w_tx_pop[ch]  = tx_host_rd_en && (tx_host_rd_ch == CH_W'(ch)) && !w_tx_empty[ch];
        assign w_tx_push[ch] = w_client_wr && (wr_ch_sel == CH_W'(ch))
                               && (!w_tx_full[ch] || w_tx_pop[ch]);

        assign w_rx_head[ch] = r_rx_mem[r_rx_rptr];
        assign w_tx_head[ch] = r_tx_mem[r_tx_rptr];

        assign rxf_n[ch] = !rst_n || w_rx_empty[ch];
        assign txe_n[ch] = !rst_n || w_tx_full[ch];

        always_ff @(posedge clk) begin
            if (w_rx_push[ch]) r_rx_mem[r_rx_wptr] <= {rx_host_wr_data, w_host_be};
            if (w_tx_push[ch]) r_tx_mem[r_tx_wptr] <= {data, w_bus_be};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rx_wptr <= '0;
                r_rx_rptr <= '0;
                r_rx_cnt  <= '0;
                r_tx_wptr <= '0;
                r_tx_rptr <= '0;
                r_tx_cnt  <= '0;
            end else begin
                if (w_rx_push[ch]) r_rx_wptr <= r_rx_wptr + AW'(1);
                if (w_rx_pop[ch])  r_rx_rptr <= r_rx_rptr + AW'(1);
                if (w_tx_push[ch]) r_tx_wptr <= r_tx_wptr + AW'(1);
                if (w_tx_pop[ch])  r_tx_rptr <= r_tx_rptr + AW'(1);
                r_rx_cnt <= r_rx_cnt + CW'(w_rx_push[ch]) - CW'(w_rx_pop[ch]);
                r_tx_cnt <= r_tx_cnt + CW'(w_tx_push[ch]) - CW'(w_tx_pop[ch]);
            end
        end
    end

    always_comb begin
        w_rx_sel_head  = '0;
        w_rx_sel_empty = 1'b1;
        w_tx_sel_head  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_sel == CH_W'(i)) begin
                w_rx_sel_head  = w_rx_head[i];
                w_rx_sel_empty = w_rx_empty[i];
            end
            if (tx_host_rd_ch == CH_W'(i)) begin
                w_tx_sel_head = w_tx_head[i];
            end
        end
    end

    assign w_bus_word = w_rx_sel_empty ? '0 : w_rx_sel_head;
    assign data = oe_n ? {DATA_WIDTH{1'bz}} : w_bus_word[WW-1:BE_W];
    assign be   = oe_n ? {BE_W{1'bz}}
                       : ((USE_BE != 0) ? w_bus_word[BE_W-1:0] : C_BE_ONES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_host_rd_valid <= 1'b0;
            tx_host_rd_data  <= '0;
            tx_host_rd_be    <= '0;
        end else begin
            tx_host_rd_valid <= |w_tx_pop;
            if (|w_tx_pop) {tx_host_rd_data, tx_host_rd_be} <= w_tx_sel_head;
        end
    end

`ifdef FT600_FIFO_ERR_EN
    logic [NUM_CH-1:0] w_rx_ovf, w_rx_udf, w_tx_ovf, w_tx_udf;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_err
        assign w_rx_ovf[ch] = rx_host_wr_en && (rx_host_wr_ch == CH_W'(ch))
                              && w_rx_full[ch] && !w_rx_pop[ch];
        assign w_rx_udf[ch] = w_client_rd && (rd_ch_sel == CH_W'(ch)) && w_rx_empty[ch];
        assign w_tx_ovf[ch] = w_client_wr && (wr_ch_sel == CH_W'(ch))
                              && w_tx_full[ch] && !w_tx_pop[ch];
        assign w_tx_udf[ch] = tx_host_rd_en && (tx_host_rd_ch == CH_W'(ch)) && w_tx_empty[ch];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= 4'b0000;
        end else begin
            err_flags <= err_flags | {|w_tx_udf, |w_tx_ovf, |w_rx_udf, |w_rx_ovf};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ft600_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft600_fifo
// Purpose  : Directed and randomized checks of ft600_fifo against a queue model.
// Revision : 1.0
// ============================================================================
module tb_ft600_fifo;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oe_n, rd_n, wr_n;
    logic [0:0]  rxf_n, txe_n;
    logic [0:0]  rd_ch_sel, wr_ch_sel, rx_host_wr_ch, tx_host_rd_ch;
    logic        rx_host_wr_en;
    logic [15:0] rx_host_wr_data;
    logic [1:0]  rx_host_wr_be;
    logic        tx_host_rd_en;
    logic        tx_host_rd_valid;
    logic [15:0] tx_host_rd_data;
    logic [1:0]  tx_host_rd_be;
    wire  [15:0] data;
    wire  [1:0]  be;
    logic [15:0] cl_data;
    logic [1:0]  cl_be;
`ifdef FT600_FIFO_ERR_EN
    logic [3:0]  err_flags;
    logic [3:0]  m_err;
`endif

    assign data = oe_n ? cl_data : 16'hzzzz;
    assign be   = oe_n ? cl_be : 2'bzz;

    always #5 clk = ~clk;

    ft600_fifo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data             (data),
        .be               (be),
        .oe_n             (oe_n),
        .rd_n             (rd_n),
        .wr_n             (wr_n),
        .rxf_n            (rxf_n),
        .txe_n            (txe_n),
        .rd_ch_sel        (rd_ch_sel),
        .wr_ch_sel        (wr_ch_sel),
        .rx_host_wr_en    (rx_host_wr_en),
        .rx_host_wr_ch    (rx_host_wr_ch),
        .rx_host_wr_data  (rx_host_wr_data),
        .rx_host_wr_be    (rx_host_wr_be),
        .tx_host_rd_en    (tx_host_rd_en),
        .tx_host_rd_ch    (tx_host_rd_ch),
        .tx_host_rd_valid (tx_host_rd_valid),
        .tx_host_rd_data  (tx_host_rd_data),
        .tx_host_rd_be    (tx_host_rd_be)
`ifdef FT600_FIFO_ERR_EN
        ,
        .err_flags        (err_flags)
`endif
    );

    // Reference model: words are {data, be}
    logic [17:0] m_rx[$];
    logic [17:0] m_tx[$];
    logic        m_valid;
    logic [17:0] m_out;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus();
        chk("bus_word", {14'h0, data, be}, (m_rx.size() > 0) ? {14'h0, m_rx[0]} : 32'h0);
    endtask

    task automatic check_outputs();
        chk("rxf_n", rxf_n, (m_rx.size() == 0));
        chk("txe_n", txe_n, (m_tx.size() == DEPTH));
        chk("tx_valid", tx_host_rd_valid, m_valid);
        chk("tx_word", {tx_host_rd_data, tx_host_rd_be}, m_out);
        if (!oe_n) check_bus();
`ifdef FT600_FIFO_ERR_EN
        chk("err_flags", err_flags, m_err);
`endif
    endtask

    // Apply the current inputs to the model, clock the DUT once, compare
    task automatic cycle();
        bit rx_pop, rx_push, tx_pop, tx_push;
        rx_pop  = !oe_n && !rd_n && (m_rx.size() > 0);
        rx_push = rx_host_wr_en && ((m_rx.size() < DEPTH) || rx_pop);
        tx_pop  = tx_host_rd_en && (m_tx.size() > 0);
        tx_push = !wr_n && oe_n && ((m_tx.size() < DEPTH) || tx_pop);
`ifdef FT600_FIFO_ERR_EN
        if (rx_host_wr_en && !rx_push) m_err[0] = 1'b1;
        if (!oe_n && !rd_n && m_rx.size() == 0) m_err[1] = 1'b1;
        if (!wr_n && oe_n && !tx_push) m_err[2] = 1'b1;
        if (tx_host_rd_en && m_tx.size() == 0) m_err[3] = 1'b1;
`endif
        if (rx_pop) void'(m_rx.pop_front());
        if (rx_push) m_rx.push_back({rx_host_wr_data, rx_host_wr_be});
        m_valid = tx_pop;
        if (tx_pop) m_out = m_tx.pop_front();
        if (tx_push) m_tx.push_back({cl_data, cl_be});
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_valid = 1'b0;
        m_out   = '0;
`ifdef FT600_FIFO_ERR_EN
        m_err   = 4'b0000;
`endif
    endtask

    task automatic host_write(input logic [15:0] d, input logic [1:0] b);
        rx_host_wr_en   = 1'b1;
        rx_host_wr_data = d;
        rx_host_wr_be   = b;
        cycle();
        rx_host_wr_en   = 1'b0;
    endtask

    task automatic client_write(input logic [15:0] d, input logic [1:0] b);
        cl_data = d;
        cl_be   = b;
        wr_n    = 1'b0;
        cycle();
        wr_n    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        rd_ch_sel = '0; wr_ch_sel = '0; rx_host_wr_ch = '0; tx_host_rd_ch = '0;
        rx_host_wr_en = 1'b0; rx_host_wr_data = '0; rx_host_wr_be = '0;
        tx_host_rd_en = 1'b0; cl_data = '0; cl_be = '0;
        model_reset();

        // Reset asserted: flags held high, host output cleared
        #1 rst_n = 1'b0;
        #1;
        chk("reset_rxf_n", rxf_n, 1);
        chk("reset_txe_n", txe_n, 1);
        chk("reset_valid", tx_host_rd_valid, 0);
        chk("reset_tx_word", {tx_host_rd_data, tx_host_rd_be}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("release_rxf_n", rxf_n, 1);
        chk("release_txe_n", txe_n, 0);

        // Single host word, single client read
        host_write(16'hBEEF, 2'b11);
        chk("beef_rxf_low", rxf_n, 0);
        oe_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("beef_on_bus", data, 16'hBEEF);
        cycle();
        chk("beef_rxf_high", rxf_n, 1);
        chk("empty_bus_zero", data, 16'h0000);
        oe_n = 1'b1; rd_n = 1'b1;

        // Back-to-back host writes read in order
        host_write(16'hAA00, 2'b11);
        host_write(16'hBB01, 2'b11);
        oe_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("order_first", data, 16'hAA00);
        cycle();
        chk("order_second", data, 16'hBB01);
        cycle();
        oe_n = 1'b1; rd_n = 1'b1;

        // Client writes drained by the host
        client_write(16'hBEEF, 2'b11);
        client_write(16'hAA00, 2'b11);
        client_write(16'hBB01, 2'b11);
        tx_host_rd_en = 1'b1;
        cycle();
        chk("tx0_valid", tx_host_rd_valid, 1);
        chk("tx0_data", tx_host_rd_data, 16'hBEEF);
        chk("tx0_be", tx_host_rd_be, 2'b11);
        cycle();
        chk("tx1_data", tx_host_rd_data, 16'hAA00);
        cycle();
        chk("tx2_data", tx_host_rd_data, 16'hBB01);
        chk("tx2_be", tx_host_rd_be, 2'b11);
        cycle();
        chk("tx_empty_valid", tx_host_rd_valid, 0);
        chk("tx_held_data", tx_host_rd_data, 16'hBB01);
        tx_host_rd_en = 1'b0;

        // 33 host writes: the last is dropped
        for (int i = 0; i < 33; i++) host_write(16'($urandom), 2'($urandom));
`ifdef FT600_FIFO_ERR_EN
        chk("rx_overflow_flag", err_flags[0], 1);
`endif
        oe_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 31; i++) cycle();
        chk("rx_31_drained", rxf_n, 0);
        cycle();
        chk("rx_32_drained", rxf_n, 1);
        oe_n = 1'b1; rd_n = 1'b1;

        // Full TX FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) client_write(16'($urandom), 2'($urandom));
        chk("tx_full_txe", txe_n, 1);
        cl_data = 16'h5A5A; cl_be = 2'b10;
        wr_n = 1'b0; tx_host_rd_en = 1'b1;
        cycle();
        chk("tx_full_swap_txe", txe_n, 1);
        chk("tx_full_swap_valid", tx_host_rd_valid, 1);
        wr_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        chk("tx_drained_txe", txe_n, 0);
        chk("tx_last_word", {tx_host_rd_data, tx_host_rd_be}, {16'h5A5A, 2'b10});
        tx_host_rd_en = 1'b0;

        // Randomized traffic: fill-biased first half, drain-biased second half
        for (int i = 0; i < 600; i++) begin
            int p_in, p_out;
            p_in  = (i < 300) ? 85 : 25;
            p_out = (i < 300) ? 25 : 85;
            rx_host_wr_en   = ($urandom_range(0, 99) < p_in);
            rx_host_wr_data = 16'($urandom);
            rx_host_wr_be   = 2'($urandom);
            oe_n            = ($urandom_range(0, 99) >= p_out / 2 + 10);
            rd_n            = ($urandom_range(0, 99) >= p_out);
            wr_n            = ($urandom_range(0, 99) >= p_in);
            cl_data         = 16'($urandom);
            cl_be           = 2'($urandom);
            tx_host_rd_en   = ($urandom_range(0, 99) < p_out);
            cycle();
        end
        rx_host_wr_en = 1'b0; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; tx_host_rd_en = 1'b0;
        cycle();

        // Reset in the middle of a transfer with words queued
        for (int i = 0; i < 5; i++) host_write(16'($urandom), 2'($urandom));
        client_write(16'h1234, 2'b01);
        oe_n = 1'b0; rd_n = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rxf_n", rxf_n, 1);
        chk("midrst_txe_n", txe_n, 1);
        chk("midrst_valid", tx_host_rd_valid, 0);
        chk("midrst_tx_word", {tx_host_rd_data, tx_host_rd_be}, 0);
`ifdef FT600_FIFO_ERR_EN
        chk("midrst_err", err_flags, 0);
`endif
        oe_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("midrst_release_rxf_n", rxf_n, 1);
        chk("midrst_release_txe_n", txe_n, 0);
        oe_n = 1'b0;
        #1;
        check_bus();
        oe_n = 1'b1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ft600_fifo.md
FT600_FIFO -- requirements
Module: ft600_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FT bus data width.
REQ-002 SHALL have parameter NUM_CH, default 1, number of channels, each with its own RX and TX FIFO.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, entries per FIFO, power of two.
REQ-004 SHALL have parameter USE_BE, default 1; when 1 the byte enables are stored and driven, when 0 `be` is driven all-ones and ignored on writes.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, ft_clk domain.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port data, inout, DATA_WIDTH bits: FT data bus.
REQ-008 SHALL have port be, inout, DATA_WIDTH/8 bits: FT byte enables.
REQ-009 SHALL have ports oe_n, rd_n and wr_n, each input, 1 bit: active-low strobes from the FPGA client.
REQ-010 SHALL have ports rxf_n and txe_n, each output, NUM_CH bits: per-channel RX-not-empty and TX-not-full flags, active low.
REQ-011 SHALL have ports rd_ch_sel and wr_ch_sel, each input, max(1,$clog2(NUM_CH)) bits: channel targeted by client reads and writes.
REQ-012 SHALL have host RX inputs: rx_host_wr_en (1 bit), rx_host_wr_ch (channel width), rx_host_wr_data (DATA_WIDTH), rx_host_wr_be (DATA_WIDTH/8).
REQ-013 SHALL have host TX inputs rx... namely tx_host_rd_en (1 bit) and tx_host_rd_ch (channel width), and outputs tx_host_rd_valid (1 bit), tx_host_rd_data (DATA_WIDTH) and tx_host_rd_be (DATA_WIDTH/8).

Function
REQ-014 SHALL store a host word {data, be} in RX FIFO[rx_host_wr_ch] on each posedge with rx_host_wr_en=1; a write to a full FIFO is dropped.
REQ-015 SHALL drive rxf_n[ch]=0 exactly when RX FIFO[ch] is non-empty, and txe_n[ch]=0 exactly when TX FIFO[ch] is not full; both flags are combinational from the FIFO counts.
REQ-016 SHALL drive data and be with the RX FIFO[rd_ch_sel] head (first-word fall-through) while oe_n=0, and drive Z otherwise; with an empty FIFO it drives all-zeros.
REQ-017 SHALL pop RX FIFO[rd_ch_sel] on a posedge when oe_n=0, rd_n=0 and the FIFO is non-empty; the next word appears on data the same cycle after that edge.
REQ-018 SHALL push the bus {data, be} into TX FIFO[wr_ch_sel] on a posedge when wr_n=0, oe_n=1 and the FIFO is not full.
REQ-019 SHALL ignore wr_n when oe_n=0 (bus turnaround) and ignore rd_n when oe_n=1.
REQ-020 SHALL pop TX FIFO[tx_host_rd_ch] on a posedge when tx_host_rd_en=1 and the FIFO is non-empty; tx_host_rd_valid=1 with tx_host_rd_data/tx_host_rd_be follows registered one cycle later, else valid=0 with data held.
REQ-021 SHALL allow a simultaneous push and pop on one FIFO in the same cycle (count unchanged), including when full (the pop frees the slot) or empty (a push into an empty FIFO is not popped that cycle).
REQ-022 SHALL wrap its FIFO pointers modulo FIFO_DEPTH and track count in $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously clear all pointers and counts, set tx_host_rd_valid=0, tx_host_rd_data=0 and tx_host_rd_be=0, and hold rxf_n all-ones and txe_n all-ones.
REQ-024 SHALL, after reset release, present rxf_n all-ones and txe_n all-zeros, with no stale words in any FIFO.

Configuration
REQ-025 SHALL, with macro FT600_FIFO_ERR_EN defined, add output err_flags[3:0], sticky until reset: bit0 RX overflow, bit1 client read from an empty RX FIFO, bit2 TX overflow, bit3 host read from an empty TX FIFO.
REQ-026 SHALL, without FT600_FIFO_ERR_EN, omit the err_flags port and silently ignore those events.

Verification
REQ-027 SHALL pass: after reset, host writes 0xBEEF -> rxf_n[0] falls the next cycle; client oe_n=0, rd_n=0 for one cycle -> data=0xBEEF, rxf_n[0] returns to 1.
REQ-028 SHALL pass: host writes 0xAA00 and 0xBB01 back to back -> the client reads them in order over two consecutive rd_n cycles.
REQ-029 SHALL pass: client writes 0xBEEF, 0xAA00, 0xBB01 with wr_n=0, then the host pulses tx_host_rd_en for 3 cycles -> valid on 3 cycles with data 0xBEEF, 0xAA00, 0xBB01 and be=0x3.
REQ-030 SHALL pass: 33 host writes -> 32 stored, the 33rd dropped, and err_flags[0]=1 when FT600_FIFO_ERR_EN is defined.
REQ-031 SHALL pass: TX FIFO filled to 32 words -> txe_n[0]=1; a simultaneous client write and host read -> the write is accepted and count stays 32.
REQ-032 SHALL pass: rst_n asserted mid-transfer with 5 words queued -> flags reset immediately, and after release rxf_n[0]=1.
